// File: rtl/mips_bus_ram_slave.sv
// Word-addressed RAM slave for the mips_cpu_bus master: fixed read/write wait
// states, byte-lane writes, base-address decode and a sticky access error flag.
module mips_bus_ram_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          READ_WAIT   = 2,
  parameter int          WRITE_WAIT  = 1,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] address,
  input  logic [3:0]  byteenable,
  input  logic [31:0] writedata,
  output logic        waitrequest,
  output logic [31:0] readdata,
  output logic        access_error
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] READ_W4  = 4'(READ_WAIT);
  localparam logic [3:0] WRITE_W4 = 4'(WRITE_WAIT);

  typedef enum logic {IDLE, STALL} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] readdata_q, readdata_d;
  logic        access_error_q, access_error_d;

  logic        req;
  logic        accept;
  logic [3:0]  wait_tgt;
  logic [29:0] word_off;
  logic [AW-1:0] idx;
  logic        addr_valid;
  logic        do_write;
  logic        do_read;
  logic [31:0] rd_word;

  logic [31:0] mem [DEPTH_WORDS];

  // A simultaneous read+write is treated as a write for wait-state purposes.
  assign req      = read | write;
  assign wait_tgt = write ? WRITE_W4 : READ_W4;

  assign word_off   = address[31:2] - BASE_ADDR[31:2];
  assign idx        = word_off[AW-1:0];
  assign addr_valid = (address >= BASE_ADDR) && (word_off < 30'(DEPTH_WORDS))
                      && (address[1:0] == 2'b00);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      cnt_q          <= 4'd0;
      readdata_q     <= 32'd0;
      access_error_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      readdata_q     <= readdata_d;
      access_error_q <= access_error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = 4'd0;
        if (req && (wait_tgt != 4'd0)) begin
          state_d = STALL;
          cnt_d   = 4'd1;
        end
      end
      STALL: begin
        if (!req) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q < wait_tgt) begin
          cnt_d = cnt_q + 4'd1;
        end else begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_comb begin
    waitrequest = req && (cnt_q < wait_tgt);
    accept      = req && !waitrequest;
  end

  assign do_write = accept && write && !read && addr_valid;
  assign do_read  = accept && read && !write;
  assign rd_word  = addr_valid ? mem[idx] : 32'd0;

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (do_write && byteenable[b]) mem[idx][b*8 +: 8] <= writedata[b*8 +: 8];
    end
  end

  // Disabled lanes keep whatever the previous read left there.
  always_comb begin
    readdata_d = readdata_q;
    for (int b = 0; b < 4; b++) begin
      if (do_read && byteenable[b]) readdata_d[b*8 +: 8] = rd_word[b*8 +: 8];
    end
  end

  // Address 0 is the CPU halt fetch and is deliberately not an error.
  always_comb begin
    access_error_d = access_error_q;
    if (accept && ((read && write) || (!addr_valid && (address != 32'd0))))
      access_error_d = 1'b1;
  end

  assign readdata     = readdata_q;
  assign access_error = access_error_q;

endmodule
